// File: rtl/reg_set_pkg.sv
`default_nettype none
// ============================================================================
// Package     : reg_set_pkg
// Description : SD host register-set map constants, FSM states and requester
//               ids. REG_ARB_W1C_EN adds the read-modify-write states.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_set_pkg;

  localparam int unsigned ADDR_W_DEF = 7;
  localparam int unsigned DATA_W_DEF = 16;

  localparam int unsigned RESP_LO    = 6;
  localparam int unsigned RESP_HI    = 13;
  localparam int unsigned PSTATE_LO  = 16;
  localparam int unsigned PSTATE_HI  = 17;
  localparam int unsigned CAPS_LO    = 32;
  localparam int unsigned CAPS_HI    = 39;
  localparam int unsigned VERSION    = 127;
  localparam int unsigned INT_NORMAL = 24;
  localparam int unsigned INT_ERROR  = 25;

`ifdef REG_ARB_W1C_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_RDATA  = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4
  } arb_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_RDATA  = 3'd2
  } arb_state_e;
`endif

  typedef enum logic {
    REQ_HOST = 1'b0,
    REQ_CORE = 1'b1
  } req_id_e;

  // Words the host may read but never modify.
  function automatic logic is_host_ro(input int unsigned a);
    return (a >= RESP_LO && a <= RESP_HI) || (a >= PSTATE_LO && a <= PSTATE_HI) ||
           (a >= CAPS_LO && a <= CAPS_HI) || (a == VERSION);
  endfunction

  function automatic logic is_int_status(input int unsigned a);
    return (a == INT_NORMAL) || (a == INT_ERROR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin arbiter; the last-grant pointer
//               advances on every grant and resets to host-first.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
  import reg_set_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_host,
  input  logic req_core,
  output logic gnt_host,
  output logic gnt_core
);

  req_id_e last_q;
  req_id_e last_d;

  always_comb begin
    gnt_host = en && req_host && (!req_core || (last_q == REQ_CORE));
    gnt_core = en && req_core && (!req_host || (last_q == REQ_HOST));
    last_d   = last_q;
    if (gnt_host) begin
      last_d = REQ_HOST;
    end else if (gnt_core) begin
      last_d = REQ_CORE;
    end
  end

  // Pretending the core went last gives the host first turn out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ_CORE;
    end else begin
      last_q <= last_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_access_arbiter
// Description : Sequences host and SD-core accesses to the single-port register
//               memory. REG_ARB_W1C_EN enables W1C/W1S RMW on words 24/25.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_access_arbiter #(
  parameter int ADDR_W = reg_set_pkg::ADDR_W_DEF,
  parameter int DATA_W = reg_set_pkg::DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [1:0]        host_be,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic [1:0]        core_be,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  import reg_set_pkg::*;

  arb_state_e        state_q, state_d;
  req_id_e           owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [1:0]        mem_be_q, mem_be_d;
  logic              host_rvalid_q, host_rvalid_d;
  logic              core_rvalid_q, core_rvalid_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic              busy_q, busy_d;
`ifdef REG_ARB_W1C_EN
  logic [1:0]        be_q, be_d;
  logic [DATA_W-1:0] be_mask;
  logic [DATA_W-1:0] merged;
`endif

  logic              gnt_host, gnt_core;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]        sel_be;

  // No grant may escape while reset is held, even with a request pending.
  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       ((state_q == ST_IDLE) && rst_n),
    .req_host (host_req),
    .req_core (core_req),
    .gnt_host (gnt_host),
    .gnt_core (gnt_core)
  );

  always_comb begin
    sel_we    = gnt_core ? core_we    : host_we;
    sel_addr  = gnt_core ? core_addr  : host_addr;
    sel_wdata = gnt_core ? core_wdata : host_wdata;
    sel_be    = gnt_core ? core_be    : host_be;
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
`ifdef REG_ARB_W1C_EN
    be_d          = be_q;
`endif
    mem_en_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_be_d      = 2'b00;
    host_rvalid_d = 1'b0;
    core_rvalid_d = 1'b0;
    host_rdata_d  = host_rdata_q;
    core_rdata_d  = core_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt_host || gnt_core) begin
          owner_d = gnt_core ? REQ_CORE : REQ_HOST;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
`ifdef REG_ARB_W1C_EN
          be_d    = sel_be;
`endif
          state_d = ST_ACCESS;
          if (!sel_we) begin
            mem_en_d = 1'b1;
            mem_be_d = 2'b11;
          end
`ifdef REG_ARB_W1C_EN
          else if (is_int_status(32'(sel_addr))) begin
            state_d  = ST_RMW_RD;
            mem_en_d = 1'b1;
            mem_be_d = 2'b11;
          end
`endif
          // Host writes to read-only words still take the slot but never strobe.
          else if (!(gnt_host && is_host_ro(32'(sel_addr)))) begin
            mem_en_d = 1'b1;
            mem_we_d = 1'b1;
            mem_be_d = sel_be;
          end
        end
      end
      ST_ACCESS: begin
        state_d = we_q ? ST_IDLE : ST_RDATA;
      end
      ST_RDATA: begin
        state_d = ST_IDLE;
        if (owner_q == REQ_CORE) begin
          core_rvalid_d = 1'b1;
          core_rdata_d  = mem_rdata;
        end else begin
          host_rvalid_d = 1'b1;
          host_rdata_d  = mem_rdata;
        end
      end
`ifdef REG_ARB_W1C_EN
      ST_RMW_RD: begin
        state_d  = ST_RMW_WR;
        mem_en_d = 1'b1;
        mem_we_d = 1'b1;
        mem_be_d = 2'b11;
      end
      ST_RMW_WR: begin
        state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      owner_q       <= REQ_HOST;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
`ifdef REG_ARB_W1C_EN
      be_q          <= 2'b00;
`endif
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_be_q      <= 2'b00;
      host_rvalid_q <= 1'b0;
      core_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
      core_rdata_q  <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
`ifdef REG_ARB_W1C_EN
      be_q          <= be_d;
`endif
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_be_q      <= mem_be_d;
      host_rvalid_q <= host_rvalid_d;
      core_rvalid_q <= core_rvalid_d;
      host_rdata_q  <= host_rdata_d;
      core_rdata_q  <= core_rdata_d;
      busy_q        <= busy_d;
    end
  end

`ifdef REG_ARB_W1C_EN
  // Old value arrives from memory during RMW_WR and is merged on the fly.
  assign be_mask   = {{(DATA_W/2){be_q[1]}}, {(DATA_W/2){be_q[0]}}};
  assign merged    = (owner_q == REQ_HOST) ? (mem_rdata & ~(wdata_q & be_mask))
                                           : (mem_rdata |  (wdata_q & be_mask));
  assign mem_wdata = (state_q == ST_RMW_WR) ? merged : wdata_q;
`else
  assign mem_wdata = wdata_q;
`endif

  assign host_gnt    = gnt_host;
  assign core_gnt    = gnt_core;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;
  assign core_rvalid = core_rvalid_q;
  assign core_rdata  = core_rdata_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = addr_q;
  assign mem_be      = mem_be_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_access_arbiter
// Description : Scoreboard bench for reg_access_arbiter with a behavioural
//               register-set model; honours REG_ARB_W1C_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [6:0]  host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic [1:0]  host_be = '0;
  logic        host_gnt, host_rvalid;
  logic [15:0] host_rdata;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [6:0]  core_addr = '0;
  logic [15:0] core_wdata = '0;
  logic [1:0]  core_be = '0;
  logic        core_gnt, core_rvalid;
  logic [15:0] core_rdata;
  logic        mem_en, mem_we;
  logic [6:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;
  logic [15:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  reg_access_arbiter #(.ADDR_W(7), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_be(host_be), .host_gnt(host_gnt),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_be(core_be), .core_gnt(core_gnt),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] init_word(input int i);
    return 16'((i * 32'h1357) ^ 32'hA5A5);
  endfunction

  // Memory environment: single-port synchronous RAM plus a backdoor write port.
  logic [15:0] tb_mem [128];
  logic        bd_en = 1'b0;
  logic [6:0]  bd_addr = '0;
  logic [15:0] bd_data = '0;

  initial begin
    for (int i = 0; i < 128; i++) tb_mem[i] <= init_word(i);
    mem_rdata <= '0;
    forever begin
      @(posedge clk);
      if (bd_en) begin
        tb_mem[bd_addr] <= bd_data;
      end else if (mem_en) begin
        if (mem_we) begin
          if (mem_be[0]) tb_mem[mem_addr][7:0]  <= mem_wdata[7:0];
          if (mem_be[1]) tb_mem[mem_addr][15:8] <= mem_wdata[15:8];
        end else begin
          mem_rdata <= tb_mem[mem_addr];
        end
      end
    end
  end

  // Reference model: register image, expected memory operations and read returns.
  typedef struct { int cyc; bit we; logic [6:0] addr; logic [1:0] be; logic [15:0] wdata; } memop_t;
  typedef struct { int cyc; logic [15:0] data; } rd_t;

  logic [15:0] exp_mem [128];
  memop_t      mq[$];
  rd_t         hq[$];
  rd_t         cq[$];

  function automatic bit is_ro(input int a);
    return (a >= 6 && a <= 13) || a == 16 || a == 17 || (a >= 32 && a <= 39) || a == 127;
  endfunction

  function automatic logic [15:0] bmask(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

  initial begin
    int free_cyc;
    bit last_core, idle, eh, ec, hs, t_we;
    logic [6:0]  t_a;
    logic [15:0] t_d, t_m;
    logic [1:0]  t_be;
    memop_t mo;
    rd_t    rd;
`ifdef REG_ARB_W1C_EN
    logic [15:0] t_old, t_new;
`endif
    for (int i = 0; i < 128; i++) exp_mem[i] = init_word(i);
    free_cyc = 0;
    last_core = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_outputs",
            {host_gnt, core_gnt, host_rvalid, core_rvalid, mem_en, mem_we, mem_be, busy,
             |host_rdata, |core_rdata, |mem_addr, |mem_wdata}, 32'd0);
        mq.delete(); hq.delete(); cq.delete();
        free_cyc  = cyc;
        last_core = 1'b1;
      end else begin
        if (bd_en) exp_mem[bd_addr] = bd_data;
        chk("busy", busy, cyc < free_cyc);
        idle = (cyc >= free_cyc);
        eh = idle && host_req && (!core_req || last_core);
        ec = idle && core_req && (!host_req || !last_core);
        chk("grant", {host_gnt, core_gnt}, {eh, ec});

        if (mq.size() > 0 && mq[0].cyc == cyc) begin
          mo = mq.pop_front();
          chk("mem_en", mem_en, 1);
          chk("mem_we", mem_we, mo.we);
          chk("mem_addr", mem_addr, mo.addr);
          if (mo.we) begin
            chk("mem_be", mem_be, mo.be);
            chk("mem_wdata", mem_wdata, mo.wdata);
          end
        end else begin
          chk("mem_quiet", mem_en, 0);
        end

        if (hq.size() > 0 && hq[0].cyc == cyc) begin
          rd = hq.pop_front();
          chk("host_rvalid", host_rvalid, 1);
          chk("host_rdata", host_rdata, rd.data);
        end else begin
          chk("host_rvalid_quiet", host_rvalid, 0);
        end
        if (cq.size() > 0 && cq[0].cyc == cyc) begin
          rd = cq.pop_front();
          chk("core_rvalid", core_rvalid, 1);
          chk("core_rdata", core_rdata, rd.data);
        end else begin
          chk("core_rvalid_quiet", core_rvalid, 0);
        end

        if (host_gnt ^ core_gnt) begin
          hs   = host_gnt;
          t_we = hs ? host_we : core_we;
          t_a  = hs ? host_addr : core_addr;
          t_d  = hs ? host_wdata : core_wdata;
          t_be = hs ? host_be : core_be;
          t_m  = bmask(t_be);
          last_core = !hs;
          if (!t_we) begin
            mq.push_back('{cyc + 1, 1'b0, t_a, 2'b11, 16'h0});
            if (hs) hq.push_back('{cyc + 3, exp_mem[t_a]});
            else    cq.push_back('{cyc + 3, exp_mem[t_a]});
            free_cyc = cyc + 3;
          end
`ifdef REG_ARB_W1C_EN
          else if (t_a == 7'd24 || t_a == 7'd25) begin
            t_old = exp_mem[t_a];
            t_new = hs ? (t_old & ~(t_d & t_m)) : (t_old | (t_d & t_m));
            mq.push_back('{cyc + 1, 1'b0, t_a, 2'b11, 16'h0});
            mq.push_back('{cyc + 2, 1'b1, t_a, 2'b11, t_new});
            exp_mem[t_a] = t_new;
            free_cyc = cyc + 3;
          end
`endif
          else if (hs && is_ro(int'(t_a))) begin
            free_cyc = cyc + 2;
          end else begin
            mq.push_back('{cyc + 1, 1'b1, t_a, t_be, t_d});
            exp_mem[t_a] = (exp_mem[t_a] & ~t_m) | (t_d & t_m);
            free_cyc = cyc + 2;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic backdoor(input logic [6:0] a, input logic [15:0] d);
    bd_addr = a; bd_data = d; bd_en = 1'b1;
    step();
    bd_en = 1'b0;
  endtask

  task automatic drive(input bit core, input bit we, input logic [6:0] a,
                       input logic [15:0] d, input logic [1:0] be);
    int n = 0;
    if (core) begin
      core_we = we; core_addr = a; core_wdata = d; core_be = be; core_req = 1'b1;
    end else begin
      host_we = we; host_addr = a; host_wdata = d; host_be = be; host_req = 1'b1;
    end
    do begin @(negedge clk); n++; end while (!(core ? core_gnt : host_gnt) && n < 100);
    chk(core ? "core_gnt_wait" : "host_gnt_wait", core ? core_gnt : host_gnt, 1);
    step();
    if (core) core_req = 1'b0; else host_req = 1'b0;
  endtask

  function automatic logic [6:0] pick_addr();
    logic [6:0] hot [10] = '{7'd6, 7'd13, 7'd16, 7'd17, 7'd24, 7'd25, 7'd32, 7'd39, 7'd127, 7'd0};
    if ($urandom_range(0, 1) == 1) return hot[$urandom_range(0, 9)];
    return 7'($urandom_range(0, 127));
  endfunction

  task automatic rand_driver(input bit core, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) step();
      drive(core, 1'($urandom_range(0, 1)), pick_addr(), 16'($urandom),
            2'($urandom_range(1, 3)));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int nh, nc, n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Both sides hold write requests straight out of reset.
    host_we = 1'b1; host_addr = 7'd40; host_wdata = 16'h1111; host_be = 2'b11;
    core_we = 1'b1; core_addr = 7'd41; core_wdata = 16'h2222; core_be = 2'b11;
    host_req = 1'b1; core_req = 1'b1;
    nh = 0; nc = 0;
    repeat (12) begin
      @(negedge clk);
      nh += int'(host_gnt);
      nc += int'(core_gnt);
    end
    step();
    host_req = 1'b0; core_req = 1'b0;
    chk("alt_host_grants", nh, 3);
    chk("alt_core_grants", nc, 3);
    repeat (3) step();

    // Host read of the version word.
    backdoor(7'd127, 16'h0200);
    drive(1'b0, 1'b0, 7'd127, 16'h0, 2'b11);
    n = 0;
    do begin @(negedge clk); n++; end while (!host_rvalid && n < 10);
    chk("version_rvalid", host_rvalid, 1);
    chk("version_rdata", host_rdata, 16'h0200);
    step();

    // Host write to a read-only word is dropped.
    backdoor(7'd16, 16'h1234);
    drive(1'b0, 1'b1, 7'd16, 16'hFFFF, 2'b11);
    repeat (3) step();
    chk("ro_word16", tb_mem[16], 16'h1234);

    // Interrupt status word: host clear then core set.
    backdoor(7'd24, 16'h00F3);
    drive(1'b0, 1'b1, 7'd24, 16'h0003, 2'b11);
    repeat (3) step();
`ifdef REG_ARB_W1C_EN
    chk("int24_host", tb_mem[24], 16'h00F0);
`else
    chk("int24_host", tb_mem[24], 16'h0003);
`endif
    drive(1'b1, 1'b1, 7'd24, 16'h8000, 2'b11);
    repeat (3) step();
`ifdef REG_ARB_W1C_EN
    chk("int24_core", tb_mem[24], 16'h80F0);
`else
    chk("int24_core", tb_mem[24], 16'h8000);
`endif

    // Reset lands during the RDATA cycle of a host read.
    host_we = 1'b0; host_addr = 7'd5; host_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!host_gnt && n < 20);
    chk("rst_first_gnt", host_gnt, 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_no_rvalid", host_rvalid, 0);
    step();
    rst_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!host_gnt && n < 20);
    chk("rst_regrant", host_gnt, 1);
    step();
    host_req = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!host_rvalid && n < 10);
    chk("rst_read_done", host_rvalid, 1);
    chk("rst_read_data", host_rdata, init_word(5));
    step();

    // Randomised traffic from both sides.
    fork
      rand_driver(1'b0, 80);
      rand_driver(1'b1, 80);
    join
    repeat (10) step();

    chk("host_reads_drained", hq.size(), 0);
    chk("core_reads_drained", cq.size(), 0);
    chk("memops_drained", mq.size(), 0);
    for (int i = 0; i < 128; i++) chk("mem_word", tb_mem[i], exp_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_access_arbiter.md
# reg_access_arbiter

Arbitrates and sequences all accesses to the SD host register-set memory: 128 × 16-bit words, 2048 bits total, whose flat read image feeds the register-field remap logic. There are two requesters: the host bus slave and the SD core, meaning the command/data engines that post responses and status. The block grants one transaction at a time in round-robin order and drives the single-port synchronous memory. It enforces host read-only words and performs read-modify-write for the interrupt status words.

## Interface
- `ADDR_W`, default 7: word address width (128 words).
- `DATA_W`, default 16: word width.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `host_req`  in  1  host request; held with its fields until `host_gnt`.
- `host_we`  in  1  1 = write, 0 = read.
- `host_addr`  in  `ADDR_W`  word address.
- `host_wdata`  in  `DATA_W`  write data.
- `host_be`  in  2  byte enables.
- `host_gnt`  out  1  one-cycle accept pulse; fields are captured in this cycle.
- `host_rvalid`  out  1  one-cycle read-data pulse.
- `host_rdata`  out  `DATA_W`  read data; valid while `host_rvalid` is high.
- `core_req`, `core_we`, `core_addr`, `core_wdata`, `core_be`, `core_gnt`, `core_rvalid`, `core_rdata`: same as the host set, for the SD core.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write.
- `mem_addr`  out  `ADDR_W`  memory word address.
- `mem_wdata`  out  `DATA_W`  memory write data.
- `mem_be`  out  2  memory byte enables.
- `mem_rdata`  in  `DATA_W`  memory read data; valid the cycle after `mem_en` with `mem_we`=0.
- `busy`  out  1  high when the FSM is not in IDLE.

## Operation
- FSM states:
  - IDLE: accept a request.
  - ACCESS: issue the memory read or write.
  - RDATA: read data returns from memory.
  - RMW_RD: issue the memory read for a read-modify-write.
  - RMW_WR: issue the merged memory write.
- IDLE, arbitration:
  - If only one requester has `req` high, grant it.
  - If both do, grant the one not granted last.
  - The pointer resets to host-first.
  - The gnt is combinational from IDLE & req & arbitration result; all request fields are registered on that edge.
- Plain read: IDLE → ACCESS (`mem_en`=1, `mem_we`=0) → RDATA (capture `mem_rdata`) → IDLE. The registered `rvalid`/`rdata` go to the owner.
- Plain write: IDLE → ACCESS (`mem_en`=1, `mem_we`=1, `mem_be` = captured be) → IDLE.
- Host write to a read-only word:
  - Read-only words: 6–13 (responses), 16–17 (present state), 32–39 (capabilities / max current), 127 (version).
  - The transaction is granted and walks IDLE → ACCESS → IDLE with `mem_en`=0, so it is silently dropped.
  - Core writes to these words are allowed.
- Interrupt status words 24 (normal) and 25 (error), RMW, only with the feature compiled in:
  - IDLE → RMW_RD → RMW_WR → IDLE.
  - Host write is write-1-to-clear: new = old & ~(wdata masked by be).
  - Core write is write-1-to-set: new = old | (wdata masked by be).
  - The RMW_WR write uses `mem_be`=2'b11.
- Reads of any word are permitted from both sides.
- The other requester's `req` is ignored until the FSM returns to IDLE; no gnt is issued outside IDLE.
- Outputs after reset: all outputs 0, FSM in IDLE, arbitration pointer host-first.

## Timing
- The gnt edge is T.
- Plain write: memory written at T+1; next gnt possible at T+2.
- Read: `mem_en` at T+1; `rvalid` at T+3. Next gnt possible at T+3, in the same cycle as `rvalid`.
- RMW: memory read at T+1, merged write at T+2. RMW_WR uses `mem_rdata` combinationally. Next gnt possible at T+3.
- Back-to-back requests from both sides alternate with no idle cycle beyond the above.
- `rst_n` low mid-transaction:
  - Outputs clear immediately and `mem_en` drops.
  - The in-flight transaction is lost and no `rvalid` is issued.
  - A requester still holding `req` is re-arbitrated after reset release.

## Configuration
- `REG_ARB_W1C_EN` defined: interrupt status words 24/25 use RMW with W1C (host) / W1S (core) semantics.
- Not defined: words 24/25 are plain writable words for both requesters (2-cycle write); RMW_RD/RMW_WR states and the merge logic are omitted.

## Structure
- Package `reg_set_pkg` holds:
  - word address constants for the read-only words and the interrupt status words;
  - `ADDR_W`/`DATA_W` defaults;
  - the FSM state enum;
  - a requester-id typedef (HOST, CORE).
- One sub-module, `rr_arb2`: a two-requester round-robin arbiter holding the last-grant pointer, advanced on each gnt.

## Test plan
- Reset, then host read of word 127 with memory holding 16'h0200 → `host_gnt` at T, `mem_addr`=7'd127 at T+1, `host_rvalid` with `host_rdata`=16'h0200 at T+3.
- `host_req` and `core_req` both held continuously from reset, both writes → grants alternate host, core, host… every 2 cycles.
- Host write 16'hFFFF to word 16 → `host_gnt` pulses, `mem_en` never asserts, word 16 unchanged.
- With `REG_ARB_W1C_EN`, word 24 = 16'h00F3:
  - host write 16'h0003, be=2'b11 → word 24 = 16'h00F0;
  - then core write 16'h8000 → word 24 = 16'h80F0.
- Without `REG_ARB_W1C_EN`: same sequence → word 24 = 16'h0003, then 16'h8000.
- `rst_n` asserted at T+2 of a host read → no `host_rvalid`, all outputs 0; after release with `host_req` still high, gnt reissued and the read completes normally.
